aes_decrypt_block_scheduler: RTL and testbench

- Sequences AES-128 decryption over the ciphertext/key ROM.
- Loads the key into the key-expansion unit and walks the ROM address counter.
- Hands each ciphertext block to the decryption core over a valid/ready handshake, waits for the result, and writes the plaintext to the result RAM.
- Sits between the ciphertext/key ROM, the key expansion unit, the inverse-cipher core and the plaintext memory. It is the top-level control FSM of the decryption path.

---
 rtl/aes_decrypt_block_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_aes_decrypt_block_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_block_scheduler.sv
// aes_decrypt_block_scheduler: top-level control FSM of the AES-128 decryption path.
// Loads the key into key expansion, walks the ciphertext ROM, hands each block
// to the inverse-cipher core over valid/ready, and writes the plaintext to RAM.
// Optional feature macro: AES_DEC_WATCHDOG_EN (adds TIMEOUT_CYCLES and timeout_o).
module aes_decrypt_block_scheduler #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned TEXT_WIDTH = 128,
  parameter int unsigned KEY_WIDTH  = 128
`ifdef AES_DEC_WATCHDOG_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] last_addr_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  input  logic [TEXT_WIDTH-1:0] cyphertext_i,
  input  logic [KEY_WIDTH-1:0]  key_i,
  output logic [KEY_WIDTH-1:0]  key_o,
  output logic                  key_load_o,
  input  logic                  key_ready_i,
  output logic [TEXT_WIDTH-1:0] blk_data_o,
  output logic                  blk_valid_o,
  input  logic                  blk_ready_i,
  input  logic                  res_valid_i,
  input  logic [TEXT_WIDTH-1:0] res_data_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [TEXT_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef AES_DEC_WATCHDOG_EN
  ,
  output logic                  timeout_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    KEY_LOAD,
    KEY_WAIT,
    FETCH,
    ISSUE,
    WAIT_RES,
    WRITE,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic                  wd_hit_c;

  // Busy is a pure decode of the state register
  assign busy_o = (state != IDLE);

`ifdef AES_DEC_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_state_c;
  logic            wd_leave_c;

  // Which states are watched, and which input event lets each one advance
  always_comb begin
    wd_state_c = 1'b0;
    wd_leave_c = 1'b0;
    case (state)
      KEY_WAIT: begin
        wd_state_c = 1'b1;
        wd_leave_c = key_ready_i;
      end
      ISSUE: begin
        wd_state_c = 1'b1;
        wd_leave_c = blk_ready_i;
      end
      WAIT_RES: begin
        wd_state_c = 1'b1;
        wd_leave_c = res_valid_i;
      end
      default: ;
    endcase
  end

  assign wd_hit_c = wd_state_c && (wd_cnt == WD_LIMIT);

  // Dwell counter; restarts from zero whenever the FSM changes state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!wd_state_c || wd_leave_c || wd_hit_c) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // Sticky timeout flag, cleared by the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_o <= 1'b0;
    end else if ((state == IDLE) && start_i) begin
      timeout_o <= 1'b0;
    end else if (wd_hit_c) begin
      timeout_o <= 1'b1;
    end
  end
`else
  assign wd_hit_c = 1'b0;
`endif

  // Sequencing FSM with registered outputs; strobes default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_o        <= '0;
      last_addr_q <= '0;
      key_o       <= '0;
      key_load_o  <= 1'b0;
      blk_data_o  <= '0;
      blk_valid_o <= 1'b0;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      done_o      <= 1'b0;
    end else begin
      key_load_o <= 1'b0;
      wr_en_o    <= 1'b0;
      done_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            pc_o        <= '0;
            last_addr_q <= last_addr_i;
            key_o       <= key_i;
            key_load_o  <= 1'b1;
            state       <= KEY_LOAD;
          end
        end
        KEY_LOAD: begin
          state <= KEY_WAIT;
        end
        KEY_WAIT: begin
          if (wd_hit_c) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else if (key_ready_i) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          // ROM output is stable here because pc_o has not moved since WRITE
          blk_data_o  <= cyphertext_i;
          blk_valid_o <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (wd_hit_c) begin
            blk_valid_o <= 1'b0;
            done_o      <= 1'b1;
            state       <= DONE;
          end else if (blk_ready_i) begin
            blk_valid_o <= 1'b0;
            state       <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (wd_hit_c) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else if (res_valid_i) begin
            wr_data_o <= res_data_i;
            wr_addr_o <= pc_o;
            wr_en_o   <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          // Stop on the last address so pc_o never wraps
          if (pc_o == last_addr_q) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            pc_o  <= pc_o + ADDR_WIDTH'(1);
            state <= FETCH;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_block_scheduler.sv
// Scoreboard bench for aes_decrypt_block_scheduler: a ROM table, a stub core
// (plaintext = block ^ key, fixed latency) and a write-side monitor.
`timescale 1ns/1ps
module tb_aes_decrypt_block_scheduler;
  localparam int unsigned AW  = 4;
  localparam int unsigned TW  = 128;
  localparam int unsigned KW  = 128;
  localparam int          LAT = 10;
`ifdef AES_DEC_WATCHDOG_EN
  localparam int unsigned TO  = 32;
`endif
  localparam logic [KW-1:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] last_addr_i;
  logic [AW-1:0] pc_o;
  logic [TW-1:0] cyphertext_i;
  logic [KW-1:0] key_i;
  logic [KW-1:0] key_o;
  logic          key_load_o;
  logic          key_ready_i;
  logic [TW-1:0] blk_data_o;
  logic          blk_valid_o;
  logic          blk_ready_i;
  logic          res_valid_i;
  logic [TW-1:0] res_data_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [TW-1:0] wr_data_o;
  logic          busy_o;
  logic          done_o;
`ifdef AES_DEC_WATCHDOG_EN
  logic          timeout_o;
`endif

  logic [TW-1:0]    ct [16];
  logic [AW+TW-1:0] wq [$];
  logic [TW-1:0]    bq [$];

  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0, wr_cnt = 0, done_cnt = 0, kl_cnt = 0;
  int bp_cycles = 0, kdelay = 0;
  bit spur_en = 0, mute = 0, wrote_any = 0, pc_zero_after = 0;

  assign cyphertext_i = ct[pc_o];

  aes_decrypt_block_scheduler #(
    .ADDR_WIDTH(AW),
    .TEXT_WIDTH(TW),
    .KEY_WIDTH(KW)
`ifdef AES_DEC_WATCHDOG_EN
    ,
    .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .last_addr_i(last_addr_i),
    .pc_o(pc_o),
    .cyphertext_i(cyphertext_i),
    .key_i(key_i),
    .key_o(key_o),
    .key_load_o(key_load_o),
    .key_ready_i(key_ready_i),
    .blk_data_o(blk_data_o),
    .blk_valid_o(blk_valid_o),
    .blk_ready_i(blk_ready_i),
    .res_valid_i(res_valid_i),
    .res_data_i(res_data_i),
    .wr_en_o(wr_en_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .busy_o(busy_o),
    .done_o(done_o)
`ifdef AES_DEC_WATCHDOG_EN
    ,
    .timeout_o(timeout_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stub core, key expansion and ROM-side stimulus, all driven on negedge
  initial begin : core
    int vcnt, pend, kcnt;
    bit hs_prev, vprev, spur_next;
    logic [TW-1:0] pend_data, dprev;
    vcnt = 0; pend = 0; kcnt = 0;
    hs_prev = 0; vprev = 0; spur_next = 0;
    pend_data = '0; dprev = '0;
    blk_ready_i = 1'b0; res_valid_i = 1'b0; res_data_i = '0; key_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      res_valid_i = 1'b0;
      if (!rst_n) begin
        pend = 0; vcnt = 0; hs_prev = 0; vprev = 0; spur_next = 0; kcnt = 0;
        blk_ready_i = 1'b0; key_ready_i = 1'b0;
      end else begin
        if (vprev && !hs_prev) begin
          chk("blk_valid_hold", 128'(blk_valid_o), 128'(1));
          chk("blk_data_stable", 128'(blk_data_o), 128'(dprev));
        end
        if (hs_prev) begin
          hs_cnt++;
          if (bq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL handshake_extra: got block %h expected none", pend_data);
          end else begin
            chk("blk_data", 128'(pend_data), 128'(bq.pop_front()));
          end
          if (!mute) pend = LAT;
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            res_valid_i = 1'b1;
            res_data_i  = pend_data ^ KEY;
          end
        end
        if (spur_next) begin
          res_valid_i = 1'b1;
          res_data_i  = '1;
          spur_next   = 0;
        end
        if (spur_en && wr_en_o) spur_next = 1;
        if (key_load_o) begin
          kcnt = kdelay;
          key_ready_i = (kdelay == 0);
        end else if (kcnt > 0) begin
          kcnt--;
          key_ready_i = (kcnt == 0);
        end
        if (blk_valid_o) begin
          blk_ready_i = (vcnt >= bp_cycles);
          vcnt++;
        end else begin
          vcnt = 0;
          blk_ready_i = (bp_cycles == 0);
        end
        vprev   = blk_valid_o;
        dprev   = blk_data_o;
        hs_prev = blk_valid_o && blk_ready_i;
        if (hs_prev) pend_data = blk_data_o;
      end
    end
  end

  // Write-side monitor: pops the expected write queue on every wr_en_o
  initial begin : mon
    logic [AW+TW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wr_en_o) begin
          wr_cnt++;
          wrote_any = 1;
          if (wq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL write_unexpected: got addr %0d data %h expected none", wr_addr_o, wr_data_o);
          end else begin
            e = wq.pop_front();
            chk("wr_addr", 128'(wr_addr_o), 128'(e[TW +: AW]));
            chk("wr_data", 128'(wr_data_o), 128'(e[TW-1:0]));
          end
        end else if (wrote_any && busy_o && pc_o == '0) begin
          pc_zero_after = 1;
        end
        if (done_o) done_cnt++;
        if (key_load_o) begin
          kl_cnt++;
          chk("key_o", 128'(key_o), 128'(KEY));
        end
      end
    end
  end

  task automatic pulse_start(input int last);
    @(negedge clk);
    start_i = 1'b1; last_addr_i = AW'(last); key_i = KEY;
    @(negedge clk);
    start_i = 1'b0; last_addr_i = '0; key_i = '0;
  endtask

  task automatic run(input int last, input int bp, input int kd, input bit spur,
                     input bit restart, input int exp_lat);
    int cyc, first_v;
    bit seen_done;
    bp_cycles = bp; kdelay = kd; spur_en = spur;
    hs_cnt = 0; done_cnt = 0; kl_cnt = 0; wr_cnt = 0; wrote_any = 0; pc_zero_after = 0;
    for (int i = 0; i <= last; i++) begin
      wq.push_back({AW'(i), ct[i] ^ KEY});
      bq.push_back(ct[i]);
    end
    pulse_start(last);
    cyc = 1; first_v = -1; seen_done = 0;
    while (!seen_done && cyc < 3000) begin
      if (first_v < 0 && blk_valid_o) first_v = cyc;
      if (restart) begin
        start_i     = (cyc == 8);
        last_addr_i = (cyc == 8) ? AW'(15) : '0;
        key_i       = (cyc == 8) ? ~KEY : '0;
      end
      if (done_o) begin
        seen_done = 1;
        chk("busy_in_done", 128'(busy_o), 128'(1));
        chk("pc_final", 128'(pc_o), 128'(last));
        @(negedge clk);
        chk("busy_after_done", 128'(busy_o), 128'(0));
        chk("done_width", 128'(done_o), 128'(0));
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    start_i = 1'b0;
    if (!seen_done) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: got no done_o within %0d cycles expected one", cyc);
    end
    chk("first_valid_lat", 128'(first_v), 128'(exp_lat));
    repeat (4) @(negedge clk);
    chk("done_count", 128'(done_cnt), 128'(1));
    chk("key_load_count", 128'(kl_cnt), 128'(1));
    chk("handshakes", 128'(hs_cnt), 128'(last + 1));
    chk("writes", 128'(wr_cnt), 128'(last + 1));
    chk("wq_drained", 128'(wq.size()), 128'(0));
    wq.delete();
    bq.delete();
  endtask

  // Wait for the n-th falling edge of blk_valid_o (i.e. first cycle of WAIT_RES)
  task automatic wait_falls(input int n);
    int k, falls;
    bit sv;
    k = 0; falls = 0; sv = 0;
    while (falls < n && k < 500) begin
      @(negedge clk);
      k++;
      if (blk_valid_o) sv = 1;
      else if (sv) begin
        falls++;
        sv = 0;
      end
    end
    if (falls < n) begin
      n_vec++; n_err++;
      $display("FAIL wait_res_timeout: got %0d valid drops expected %0d", falls, n);
    end
  endtask

  initial begin : main
    int w0, d0;
    rst_n = 1'b0; start_i = 1'b0; last_addr_i = '0; key_i = '0;
    ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    for (int i = 1; i < 16; i++) ct[i] = ct[0] ^ {16{8'(i * 17)}};
    repeat (3) @(negedge clk);
    chk("rst_pc", 128'(pc_o), 128'(0));
    chk("rst_key", 128'(key_o), 128'(0));
    chk("rst_key_load", 128'(key_load_o), 128'(0));
    chk("rst_blk_data", 128'(blk_data_o), 128'(0));
    chk("rst_blk_valid", 128'(blk_valid_o), 128'(0));
    chk("rst_wr_en", 128'(wr_en_o), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr_o), 128'(0));
    chk("rst_wr_data", 128'(wr_data_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_done", 128'(done_o), 128'(0));
`ifdef AES_DEC_WATCHDOG_EN
    chk("rst_timeout", 128'(timeout_o), 128'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run(3, 0, 0, 0, 0, 4);    // basic four blocks
    run(0, 0, 3, 0, 0, 6);    // single block with key-wait cycles
    run(2, 5, 0, 0, 0, 4);    // backpressure in ISSUE
    run(3, 0, 0, 1, 1, 4);    // spurious result in FETCH, start while busy
    run(15, 0, 0, 0, 0, 4);   // full address range
    chk("pc_nonzero_after_first", 128'(pc_zero_after), 128'(0));

    // Asynchronous reset while waiting on the second result
    hs_cnt = 0; wr_cnt = 0; done_cnt = 0; bp_cycles = 0; kdelay = 0; spur_en = 0;
    wq.push_back({AW'(0), ct[0] ^ KEY});
    for (int i = 0; i <= 3; i++) bq.push_back(ct[i]);
    pulse_start(3);
    wait_falls(2);
    chk("pre_abort_pc", 128'(pc_o), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pc", 128'(pc_o), 128'(0));
    chk("abort_key", 128'(key_o), 128'(0));
    chk("abort_blk_data", 128'(blk_data_o), 128'(0));
    chk("abort_blk_valid", 128'(blk_valid_o), 128'(0));
    chk("abort_wr_en", 128'(wr_en_o), 128'(0));
    chk("abort_wr_addr", 128'(wr_addr_o), 128'(0));
    chk("abort_wr_data", 128'(wr_data_o), 128'(0));
    chk("abort_busy", 128'(busy_o), 128'(0));
    chk("abort_done", 128'(done_o), 128'(0));
    chk("abort_first_write", 128'(wq.size()), 128'(0));
    wq.delete();
    bq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    repeat (30) @(negedge clk);
    chk("abort_no_write", 128'(wr_cnt), 128'(w0));
    chk("abort_no_done", 128'(done_cnt), 128'(d0));

`ifdef AES_DEC_WATCHDOG_EN
    begin : wd_test
      int k;
      mute = 1; wr_cnt = 0; done_cnt = 0; bp_cycles = 0; kdelay = 0;
      bq.push_back(ct[0]);
      pulse_start(3);
      wait_falls(1);
      k = 0;
      while (!done_o && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("wd_done_lat", 128'(k), 128'(TO));
      chk("wd_timeout_set", 128'(timeout_o), 128'(1));
      @(negedge clk);
      chk("wd_timeout_sticky", 128'(timeout_o), 128'(1));
      chk("wd_no_write", 128'(wr_cnt), 128'(0));
      mute = 0;
      bq.delete();
      run(1, 0, 0, 0, 0, 4);
      chk("wd_timeout_cleared", 128'(timeout_o), 128'(0));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : guard
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish before 1ms");
    $fatal(1, "bench timeout");
  end

endmodule
